// File: rtl/spi_prog_slave_pkg.sv
// ============================================================================
// Module  : spi_prog_pkg
// Brief   : Shared types and constants for the SPI program-load slave.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_prog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] c_cmd_addr = 8'h01;
  localparam logic [7:0] c_cmd_data = 8'h02;

  // Status byte layout shifted out on miso (bits 1:0 are always zero)
  localparam int c_st_busy     = 7;
  localparam int c_st_err_cmd  = 6;
  localparam int c_st_err_ovf  = 5;
  localparam int c_st_wr_valid = 4;
  localparam int c_st_state_hi = 3;
  localparam int c_st_state_lo = 2;

  function automatic logic [7:0] status_byte(
    input logic   busy,
    input logic   err_cmd,
    input logic   err_ovf,
    input logic   wr_valid,
    input state_t st
  );
    logic [7:0] v;
    v = 8'h00;
    v[c_st_busy]     = busy;
    v[c_st_err_cmd]  = err_cmd;
    v[c_st_err_ovf]  = err_ovf;
    v[c_st_wr_valid] = wr_valid;
    v[c_st_state_hi:c_st_state_lo] = st;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_prog_slave_if.sv
// ============================================================================
// Module  : spi_prog_slave_if
// Brief   : 32-bit valid/ready write port from the SPI slave to the load path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface spi_prog_slave_if;

  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

`default_nettype wire

// File: rtl/spi_prog_slave_byte_rx.sv
// ============================================================================
// Module  : spi_slave_byte_rx
// Brief   : SPI mode-0 byte receiver with pin synchronizers; status shift-out
//           present only when SPI_PROG_STATUS_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_slave_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
`ifdef SPI_PROG_STATUS_EN
  input  logic [7:0] status,
`endif
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift;

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_sclk_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;

  // Deselect throws away any partial byte; the 3-bit counter wraps after bit 8
  always_ff @(posedge clk) begin
    if (reset || w_cs_s) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
    end else if (w_sclk_rise) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      r_shift   <= {r_shift[5:0], w_mosi_s};
    end
  end

  assign byte_valid = w_sclk_rise & ~w_cs_s & (r_bit_cnt == 3'd7);
  assign byte_data  = {r_shift, w_mosi_s};

`ifdef SPI_PROG_STATUS_EN
  logic       r_cs_d;
  logic [7:0] r_tx;
  logic       r_skip_fall;
  logic       w_cs_fall;
  logic       w_sclk_fall;

  assign w_cs_fall   = r_cs_d & ~w_cs_s;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;

  // A reload on byte_valid happens at the 8th rising edge; the falling edge
  // that follows must not shift, or the next byte would lose its MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_d      <= 1'b1;
      r_tx        <= 8'h00;
      r_skip_fall <= 1'b0;
    end else begin
      r_cs_d <= w_cs_s;
      if (w_cs_fall) begin
        r_tx        <= status;
        r_skip_fall <= 1'b0;
      end else if (byte_valid) begin
        r_tx        <= status;
        r_skip_fall <= 1'b1;
      end else if (w_sclk_fall && !w_cs_s) begin
        if (r_skip_fall) begin
          r_skip_fall <= 1'b0;
        end else begin
          r_tx <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  assign miso = ~w_cs_s & r_tx[7];
`else
  assign miso = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/spi_prog_slave.sv
// ============================================================================
// Module  : spi_prog_slave
// Brief   : SPI programming slave turning 0x01/0x02 command bytes into 32-bit
//           write transactions. Optional macro: SPI_PROG_STATUS_EN (miso status).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_prog_slave
  import spi_prog_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ADDR_INC    = 32'd4,
  parameter logic [7:0]  CMD_ADDR    = c_cmd_addr,
  parameter logic [7:0]  CMD_DATA    = c_cmd_data
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  spi_prog_slave_if.master        wr,
  output logic                    busy,
  output logic                    err_cmd,
  output logic                    err_ovf,
  input  logic                    err_clr
);

  state_t      r_state;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_addr_shift;
  logic [31:0] r_data_shift;
  logic [31:0] r_addr_reg;
  logic        r_wr_valid;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_err_cmd;
  logic        r_err_ovf;

  logic        w_byte_valid;
  logic [7:0]  w_byte;
  logic        w_accept;
  logic [31:0] w_addr_next;
  logic [31:0] w_data_next;

  spi_slave_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_byte_rx (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
`ifdef SPI_PROG_STATUS_EN
    .status     (status_byte(busy, r_err_cmd, r_err_ovf, r_wr_valid, r_state)),
`endif
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte),
    .miso       (miso)
  );

  assign w_accept    = r_wr_valid & wr.wr_ready;
  assign w_addr_next = {r_addr_shift[23:0], w_byte};
  assign w_data_next = {r_data_shift[23:0], w_byte};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_byte_idx   <= 2'd0;
      r_addr_shift <= 32'd0;
      r_data_shift <= 32'd0;
      r_addr_reg   <= 32'd0;
      r_wr_valid   <= 1'b0;
      r_wr_addr    <= 32'd0;
      r_wr_data    <= 32'd0;
      r_err_cmd    <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_valid <= 1'b0;
      end
      // Clear first so a set later in this block takes priority
      if (err_clr) begin
        r_err_cmd <= 1'b0;
        r_err_ovf <= 1'b0;
      end

      if (w_byte_valid) begin
        case (r_state)
          IDLE: begin
            r_byte_idx <= 2'd0;
            if (w_byte == CMD_ADDR) begin
              r_state <= ADDR;
            end else if (w_byte == CMD_DATA) begin
              r_state <= DATA;
            end else begin
              r_err_cmd <= 1'b1;
            end
          end

          ADDR: begin
            r_addr_shift <= w_addr_next;
            r_byte_idx   <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_addr_reg <= w_addr_next;
              r_state    <= IDLE;
            end
          end

          DATA: begin
            r_data_shift <= w_data_next;
            r_byte_idx   <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_state <= IDLE;
              // A slot is free if nothing pends or the pending word leaves now
              if (!r_wr_valid || w_accept) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr_reg;
                r_wr_data  <= w_data_next;
                r_addr_reg <= r_addr_reg + ADDR_INC;
              end else begin
                r_err_ovf <= 1'b1;
              end
            end
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign wr.wr_valid = r_wr_valid;
  assign wr.wr_addr  = r_wr_addr;
  assign wr.wr_data  = r_wr_data;
  assign busy        = (r_state != IDLE) | r_wr_valid;
  assign err_cmd     = r_err_cmd;
  assign err_ovf     = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_spi_prog_slave.sv
// ============================================================================
// Module  : tb_spi_prog_slave
// Brief   : Scoreboard bench for spi_prog_slave driven over SPI mode 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_prog_slave;

  logic clk = 1'b0;
  logic reset;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic busy;
  logic err_cmd;
  logic err_ovf;
  logic err_clr;

  spi_prog_slave_if wr_if ();

  always #5 clk = ~clk;

  spi_prog_slave dut (
    .clk     (clk),
    .reset   (reset),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .wr      (wr_if.master),
    .busy    (busy),
    .err_cmd (err_cmd),
    .err_ovf (err_ovf),
    .err_clr (err_clr)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          n_wr  = 0;
  int          n_exp = 0;
  logic [63:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted write is compared against the oldest expectation
  always @(negedge clk) begin
    if (!reset && wr_if.wr_valid && wr_if.wr_ready) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check_val("wr_unexpected", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check_val("wr_addr", {32'd0, wr_if.wr_addr}, {32'd0, e[63:32]});
        check_val("wr_data", {32'd0, wr_if.wr_data}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CS frame carrying nbits bits of b, MSB first; rx collects miso
  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    @(negedge clk);
    cs_n = 1'b0;
    clks(4);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      clks(4);
      rx   = {rx[6:0], miso};
      sclk = 1'b1;
      clks(4);
      sclk = 1'b0;
    end
    clks(2);
    cs_n = 1'b1;
    clks(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] rx;
    spi_bits(b, 8, rx);
`ifndef SPI_PROG_STATUS_EN
    check_val("miso_zero", {56'd0, rx}, 64'd0);
`endif
  endtask

  task automatic send_addr(input logic [31:0] a);
    send_byte(8'h01);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
  endtask

  task automatic send_data(input logic [31:0] d);
    send_byte(8'h02);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
    n_exp++;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000 && (exp_q.size() != 0 || wr_if.wr_valid); i++) clks(1);
    check_val("drain", {32'd0, exp_q.size()}, 64'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    clks(1);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [31:0] d;
    int          wr_base;

    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    err_clr = 1'b0; wr_if.wr_ready = 1'b1;
    clks(5);
    reset = 1'b0;
    clks(2);
    check_val("rst_wr_valid", {63'd0, wr_if.wr_valid}, 64'd0);
    check_val("rst_wr_addr",  {32'd0, wr_if.wr_addr},  64'd0);
    check_val("rst_wr_data",  {32'd0, wr_if.wr_data},  64'd0);
    check_val("rst_busy",     {63'd0, busy},    64'd0);
    check_val("rst_err_cmd",  {63'd0, err_cmd}, 64'd0);
    check_val("rst_err_ovf",  {63'd0, err_ovf}, 64'd0);
    check_val("rst_miso",     {63'd0, miso},    64'd0);

    // Single write, then confirm the address stepped by 4
    send_addr(32'h1000_0000);
    wr_base = n_wr;
    expect_wr(32'h1000_0000, 32'hDEAD_BEEF);
    send_data(32'hDEAD_BEEF);
    wait_drain();
    check_val("single_wr_count", 64'(n_wr - wr_base), 64'd1);
    expect_wr(32'h1000_0004, 32'h0000_0001);
    send_data(32'h0000_0001);
    wait_drain();

    // Streamed random words
    send_addr(32'h2000_0000);
    for (int i = 0; i < 100; i++) begin
      d = $urandom;
      expect_wr(32'h2000_0000 + 32'(i * 4), d);
      send_data(d);
    end
    wait_drain();

    // Unknown opcode in IDLE
    wr_base = n_wr;
    send_byte(8'h55);
    check_val("err_cmd_set", {63'd0, err_cmd}, 64'd1);
`ifdef SPI_PROG_STATUS_EN
    spi_bits(8'h55, 8, rx);
    check_val("miso_status", {56'd0, rx}, 64'h40);
`endif
    clks(10);
    check_val("bad_cmd_no_wr", 64'(n_wr - wr_base), 64'd0);
    pulse_clr();
    check_val("err_cmd_clr", {63'd0, err_cmd}, 64'd0);

    // Overflow: second word dropped while first is stalled
    send_addr(32'h3000_0000);
    wr_if.wr_ready = 1'b0;
    expect_wr(32'h3000_0000, 32'hA5A5_0001);
    send_data(32'hA5A5_0001);
    check_val("ovf_pending", {63'd0, wr_if.wr_valid}, 64'd1);
    send_data(32'h5A5A_0002);
    check_val("ovf_flag",   {63'd0, err_ovf}, 64'd1);
    check_val("ovf_addr",   {32'd0, wr_if.wr_addr}, 64'h3000_0000);
    check_val("ovf_data",   {32'd0, wr_if.wr_data}, 64'hA5A5_0001);
    clks(3);
    wr_if.wr_ready = 1'b1;
    wait_drain();
    expect_wr(32'h3000_0004, 32'hC0DE_0003);
    send_data(32'hC0DE_0003);
    wait_drain();
    pulse_clr();
    check_val("err_ovf_clr", {63'd0, err_ovf}, 64'd0);

    // CS abort in the middle of the second address byte
    send_byte(8'h01);
    send_byte(8'h40);
    spi_bits(8'h12, 5, rx);
`ifndef SPI_PROG_STATUS_EN
    check_val("miso_zero_partial", {56'd0, rx}, 64'd0);
`endif
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    expect_wr(32'h4012_3456, 32'h1234_5678);
    send_data(32'h1234_5678);
    wait_drain();

    // Reset mid-DATA with a write pending
    wr_if.wr_ready = 1'b0;
    send_data(32'hFFFF_0000);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    reset = 1'b1;
    clks(1);
    check_val("rst_mid_valid", {63'd0, wr_if.wr_valid}, 64'd0);
    check_val("rst_mid_busy",  {63'd0, busy}, 64'd0);
    reset = 1'b0;
    wr_if.wr_ready = 1'b1;
    clks(4);
    expect_wr(32'h0000_0000, 32'h0BAD_F00D);
    send_data(32'h0BAD_F00D);
    wait_drain();

    check_val("total_writes", 64'(n_wr), 64'(n_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
